interval_capture: RTL

Interval capture timer: measures, in enabled clock cycles, the time from a start strobe until a monitored line goes high, then holds the result until acknowledged. It is the receiving end of the one-shot `counter` block. `counter` turns a start into a delayed line assertion; `interval_capture` turns a line assertion back into a cycle count. Typical uses are timeout/latency measurement and self-checking of `counter` THRESHOLD settings in the CPU peripheral set.

---
 rtl/interval_capture.sv | 81 ++++++++
 1 files changed

// File: rtl/interval_capture.sv
// interval_capture: counts enabled cycles from a start strobe until the monitored line goes high, holding the result until acknowledged.
// Define INTERVAL_CAPTURE_SYNC_EN to pass i_line through a 2-flop synchronizer (adds 2 cycles to reported counts).
module interval_capture #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_line,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_count,
  output logic             o_valid,
  output logic             o_overflow,
  output logic             o_busy
);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  localparam logic [WIDTH-1:0] MAX = '1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, count_q, count_d;
  logic valid_q, valid_d, ovf_q, ovf_d, busy_q;
  logic line_s;
`ifdef INTERVAL_CAPTURE_SYNC_EN
  logic [1:0] sync_q;
  // synchronizer runs every cycle so the line delay is independent of i_en
  always_ff @(posedge i_clk)
    if (!i_rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], i_line};
  assign line_s = sync_q[1];
`else
  assign line_s = i_line;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (i_en && i_start) begin
        cnt_d   = '0;
        state_d = ARMED;
      end
      ARMED: if (i_en) begin
        if (i_start) cnt_d = '0;
        else if (line_s || cnt_q == MAX) begin
          count_d = cnt_q;
          valid_d = 1'b1;
          ovf_d   = !line_s;
          state_d = DONE;
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE: if (i_ack) begin
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      busy_q  <= state_d == ARMED;
    end
  assign o_count    = count_q;
  assign o_valid    = valid_q;
  assign o_overflow = ovf_q;
  assign o_busy     = busy_q;
endmodule
